alu_mt_pipe: RTL and testbench
==============================

Name: alu_mt_pipe

Overview:
- Parametrised, handshaked successor to the single-issue execute ALU.
- Accepts one instruction per cycle from the multi-thread issue stage and executes RV32I integer, LUI/AUIPC, jump and branch operations.
- Returns a registered writeback/redirect packet tagged with its thread ID.
- Shifts run through an iterative shifter of configurable step size. All other ops take one cycle. Output backpressure is supported.

Parameters:
- XLEN, 32, datapath width.
- PC_W, 30, width of the word-addressed PC (byte address = pc<<2).
- THREAD_W, 2, thread ID width.
- SHIFT_STEP, 8, bits shifted per cycle. Legal values are 1, 2, 4, 8, 16, 32. Setting it equal to XLEN makes shifts single-cycle.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  request valid.
- in_ready  out  1  block can accept a request this cycle.
- op  in  3  class: 0 REG, 1 IMM, 2 LUI, 3 AUIPC, 4 JAL, 5 JALR, 6 BRANCH, 7 reserved.
- funct3  in  3  RISC-V funct3.
- alt  in  1  SUB (REG class only) or SRA select.
- rs1_data  in  XLEN  source 1.
- rs2_data  in  XLEN  source 2.
- imm  in  XLEN  sign-extended immediate.
- pc  in  PC_W  word PC of the instruction.
- rd_en  in  1  writeback requested.
- rd_addr  in  5  destination register.
- thread_id  in  THREAD_W  issuing thread.
- out_valid  out  1  output packet valid.
- out_ready  in  1  consumer accepts the packet.
- out_rd_en  out  1  writeback enable.
- out_rd_addr  out  5  destination register.
- out_rd_data  out  XLEN  writeback data.
- out_thread_id  out  THREAD_W  thread tag.
- out_redirect  out  1  control flow taken (JAL, JALR, taken branch).
- out_new_pc  out  PC_W  next PC for this thread.
- out_misalign  out  1  redirect target has byte-address bit 1 set.
- busy  out  1  iterative shift in progress.

Behaviour:
- Handshake:
  - A request transfers on in_valid && in_ready.
  - A packet transfers on out_valid && out_ready.
  - in_ready = !rst && state==IDLE && (!out_valid || out_ready), so a request may be accepted in the same cycle the current packet drains.
  - The packet stays stable while out_valid && !out_ready.
- FSM states: IDLE, SHIFT.
  - Non-shift op accepted in IDLE: the result is registered and out_valid=1 on the next edge (latency 1).
  - Shift op (funct3 001/101 in REG/IMM) with SHIFT_STEP<XLEN goes to SHIFT.
    - The operands, shamt = op2[4:0] and the tag are latched.
    - Each cycle shifts by min(remaining, SHIFT_STEP). Logical shifts fill with 0; SRA fills with the sign bit.
    - When remaining reaches 0, the FSM returns to IDLE and out_valid is set on that edge.
    - Latency is max(1, ceil(shamt/SHIFT_STEP)) cycles. shamt=0 takes 1 cycle.
    - busy=1 while in SHIFT.
- Operand 2 is rs2_data for REG and BRANCH, and imm otherwise.
- Arithmetic:
  - SUB applies only in the REG class. For IMM, alt is ignored except for SRAI.
  - SLT compares signed (sign XOR overflow of the subtraction). SLTU uses the borrow.
  - LUI result = imm.
  - AUIPC result = (pc<<2)+imm.
  - All sums are modulo 2^XLEN.
- Control flow:
  - JAL target = (pc<<2)+imm. JALR target = (rs1+imm)&~1. Branch target = (pc<<2)+imm.
  - BEQ, BNE, BLT, BGE, BLTU, BGEU are evaluated on rs1 vs rs2. funct3 010/011 under BRANCH means not taken.
  - JAL/JALR: rd data = (pc+1)<<2.
  - out_new_pc = taken ? target[PC_W+1:2] : pc+1, wrapping modulo 2^PC_W.
  - out_misalign = taken && target[1]. When out_misalign=1, out_rd_en is forced to 0.
  - Branches always have out_rd_en=0.
- op=7 (reserved): the packet is still produced with out_rd_en=0, out_redirect=0, new_pc=pc+1.
- rd_addr=0: out_rd_en=0 regardless of rd_en.
- Reset:
  - out_valid=0, state=IDLE, busy=0.
  - All out_* data outputs are 0.
  - in_ready=0 during rst.
  - A reset mid-shift abandons the operation and no packet is emitted.
- Packets never reorder and never drop. Exactly one packet is produced per accepted request.

Test Plan:
- ADD rs1=0x7FFFFFFF, rs2=1, rd=5, tid=2 -> next cycle out_valid, rd_data=0x80000000, rd_addr=5, thread_id=2.
- SLT -1 vs 1 gives 1; SLTU 0xFFFFFFFF vs 1 gives 0; SUB 0 - 1 gives 0xFFFFFFFF.
- SRA 0x80000000 by 31, SHIFT_STEP=8 -> busy for 4 cycles, in_ready=0 during that time, rd_data=0xFFFFFFFF. Repeat with shamt=0 -> 1 cycle, data unchanged.
- BLTU rs1=1, rs2=2, pc=0x100, imm=-8 -> out_redirect=1, new_pc=0x0FE, rd_en=0. The same inputs with BGEU give new_pc=0x101, redirect=0.
- JALR rs1=0x1002, imm=0 -> out_misalign=1, rd_en=0. JALR rs1=0x1000, pc=0x10 -> new_pc=0x400, rd_data=0x44.
- Hold out_ready=0 for 3 cycles with back-to-back valid requests -> packet stable, in_ready=0. Then release -> two packets arrive in order with no loss. Finally assert rst mid-shift -> out_valid=0 next cycle and no packet.

Source files
------------

// File: rtl/alu_mt_pipe.sv
// alu_mt_pipe: handshaked multi-thread execute ALU. Runs RV32I integer,
// LUI/AUIPC, jump and branch ops in one cycle; shifts go through an
// iterative shifter moving SHIFT_STEP bits per cycle. Each accepted request
// yields exactly one registered, thread-tagged writeback/redirect packet.
module alu_mt_pipe #(
  parameter int XLEN       = 32,
  parameter int PC_W       = 30,
  parameter int THREAD_W   = 2,
  parameter int SHIFT_STEP = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [2:0]          op,
  input  logic [2:0]          funct3,
  input  logic                alt,
  input  logic [XLEN-1:0]     rs1_data,
  input  logic [XLEN-1:0]     rs2_data,
  input  logic [XLEN-1:0]     imm,
  input  logic [PC_W-1:0]     pc,
  input  logic                rd_en,
  input  logic [4:0]          rd_addr,
  input  logic [THREAD_W-1:0] thread_id,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_rd_en,
  output logic [4:0]          out_rd_addr,
  output logic [XLEN-1:0]     out_rd_data,
  output logic [THREAD_W-1:0] out_thread_id,
  output logic                out_redirect,
  output logic [PC_W-1:0]     out_new_pc,
  output logic                out_misalign,
  output logic                busy
);

  localparam int SH_W = $clog2(XLEN);
  // A step as wide as the datapath means shifts finish in the issue cycle.
  localparam bit ITER = (SHIFT_STEP < XLEN);

  localparam logic [2:0] OP_REG    = 3'd0;
  localparam logic [2:0] OP_IMM    = 3'd1;
  localparam logic [2:0] OP_LUI    = 3'd2;
  localparam logic [2:0] OP_AUIPC  = 3'd3;
  localparam logic [2:0] OP_JAL    = 3'd4;
  localparam logic [2:0] OP_JALR   = 3'd5;
  localparam logic [2:0] OP_BRANCH = 3'd6;

  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state_reg;

  // Datapath for the request currently presented at the input.
  logic [XLEN-1:0] op2, sum, pc_byte, pc_rel, link, target, alu_res, res_data, shift_full;
  logic [XLEN:0]   diff;
  logic [PC_W-1:0] pc_inc, next_pc;
  logic [SH_W-1:0] shamt;
  logic            ovf, lt_s, lt_u, eq, cond, taken, misalign, rd_en_eff;
  logic            is_alu, is_shift, start_shift, sra, accept;
  logic            unused_bits;

  // Iterative shifter state plus the tag of the instruction being shifted.
  logic [XLEN-1:0]     sh_val_reg, sh_step_val;
  logic [SH_W-1:0]     sh_rem_reg, sh_step;
  logic                sh_left_reg, sh_sra_reg, sh_rd_en_reg;
  logic [4:0]          sh_rd_addr_reg;
  logic [THREAD_W-1:0] sh_tid_reg;
  logic [PC_W-1:0]     sh_pc_reg;

  assign in_ready = !rst && (state_reg == IDLE) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign busy     = (state_reg == SHIFT);

  assign is_alu = (op == OP_REG) || (op == OP_IMM);
  assign op2    = ((op == OP_REG) || (op == OP_BRANCH)) ? rs2_data : imm;
  assign sum    = rs1_data + op2;
  // One subtractor gives SUB, the signed compare (sign ^ overflow) and the borrow.
  assign diff   = {1'b0, rs1_data} - {1'b0, op2};
  assign ovf    = (rs1_data[XLEN-1] != op2[XLEN-1]) && (diff[XLEN-1] != rs1_data[XLEN-1]);
  assign lt_s   = diff[XLEN-1] ^ ovf;
  assign lt_u   = diff[XLEN];
  assign eq     = (rs1_data == op2);

  assign shamt       = op2[SH_W-1:0];
  assign sra         = alt && (funct3 == 3'b101);
  assign is_shift    = is_alu && (funct3[1:0] == 2'b01);
  assign start_shift = ITER && is_shift;

  assign pc_byte = XLEN'({pc, 2'b00});
  assign pc_inc  = pc + PC_W'(1);
  assign link    = XLEN'({pc_inc, 2'b00});
  assign pc_rel  = pc_byte + imm;
  // For JALR op2 is imm, so the shared adder already holds rs1+imm.
  assign target  = (op == OP_JALR) ? {sum[XLEN-1:1], 1'b0} : pc_rel;
  assign unused_bits = target[0];

  generate
    if (ITER) begin : g_iter_shift
      assign shift_full = '0;
    end else begin : g_comb_shift
      assign shift_full = !funct3[2] ? (rs1_data << shamt) :
                          sra ? $unsigned($signed(rs1_data) >>> shamt) : (rs1_data >> shamt);
    end
  endgenerate

  // Integer result for the REG/IMM classes; alt only means SUB for REG.
  always_comb begin
    alu_res = '0;
    case (funct3)
      3'b000:         alu_res = ((op == OP_REG) && alt) ? diff[XLEN-1:0] : sum;
      3'b001, 3'b101: alu_res = shift_full;
      3'b010:         alu_res = XLEN'(lt_s);
      3'b011:         alu_res = XLEN'(lt_u);
      3'b100:         alu_res = rs1_data ^ op2;
      3'b110:         alu_res = rs1_data | op2;
      default:        alu_res = rs1_data & op2;
    endcase
  end

  // Branch condition, redirect decision and writeback data selection.
  always_comb begin
    cond = 1'b0;
    case (funct3)
      3'b000:  cond = eq;
      3'b001:  cond = !eq;
      3'b100:  cond = lt_s;
      3'b101:  cond = !lt_s;
      3'b110:  cond = lt_u;
      3'b111:  cond = !lt_u;
      default: cond = 1'b0;
    endcase
    taken    = (op == OP_JAL) || (op == OP_JALR) || ((op == OP_BRANCH) && cond);
    misalign = taken && target[1];
    next_pc  = taken ? target[PC_W+1:2] : pc_inc;
    res_data = '0;
    case (op)
      OP_REG, OP_IMM:  res_data = alu_res;
      OP_LUI:          res_data = imm;
      OP_AUIPC:        res_data = pc_rel;
      OP_JAL, OP_JALR: res_data = link;
      default:         res_data = '0;
    endcase
    rd_en_eff = rd_en && (rd_addr != 5'd0) && !misalign && is_alu_or_wb(op);
  end

  function automatic logic is_alu_or_wb(input logic [2:0] o);
    return (o != OP_BRANCH) && (o != 3'd7);
  endfunction

  // One shifter step: never more than what is left of shamt.
  always_comb begin
    sh_step     = (sh_rem_reg > SH_W'(SHIFT_STEP)) ? SH_W'(SHIFT_STEP) : sh_rem_reg;
    sh_step_val = sh_left_reg ? (sh_val_reg << sh_step) :
                  sh_sra_reg  ? $unsigned($signed(sh_val_reg) >>> sh_step) : (sh_val_reg >> sh_step);
  end

  // Control FSM and registered output packet; a drained packet clears valid
  // unless a new result lands on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      out_valid      <= 1'b0;
      out_rd_en      <= 1'b0;
      out_rd_addr    <= '0;
      out_rd_data    <= '0;
      out_thread_id  <= '0;
      out_redirect   <= 1'b0;
      out_new_pc     <= '0;
      out_misalign   <= 1'b0;
      sh_val_reg     <= '0;
      sh_rem_reg     <= '0;
      sh_left_reg    <= 1'b0;
      sh_sra_reg     <= 1'b0;
      sh_rd_en_reg   <= 1'b0;
      sh_rd_addr_reg <= '0;
      sh_tid_reg     <= '0;
      sh_pc_reg      <= '0;
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (accept) begin
            if (start_shift) begin
              state_reg      <= SHIFT;
              sh_val_reg     <= rs1_data;
              sh_rem_reg     <= shamt;
              sh_left_reg    <= !funct3[2];
              sh_sra_reg     <= sra;
              sh_rd_en_reg   <= rd_en_eff;
              sh_rd_addr_reg <= rd_addr;
              sh_tid_reg     <= thread_id;
              sh_pc_reg      <= pc_inc;
            end else begin
              out_valid     <= 1'b1;
              out_rd_en     <= rd_en_eff;
              out_rd_addr   <= rd_addr;
              out_rd_data   <= res_data;
              out_thread_id <= thread_id;
              out_redirect  <= taken;
              out_new_pc    <= next_pc;
              out_misalign  <= misalign;
            end
          end
        end
        SHIFT: begin
          sh_val_reg <= sh_step_val;
          sh_rem_reg <= sh_rem_reg - sh_step;
          if (sh_rem_reg == sh_step) begin
            state_reg     <= IDLE;
            out_valid     <= 1'b1;
            out_rd_en     <= sh_rd_en_reg;
            out_rd_addr   <= sh_rd_addr_reg;
            out_rd_data   <= sh_step_val;
            out_thread_id <= sh_tid_reg;
            out_redirect  <= 1'b0;
            out_new_pc    <= sh_pc_reg;
            out_misalign  <= 1'b0;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mt_pipe.sv
// tb_alu_mt_pipe: directed bench for alu_mt_pipe with default parameters
// (SHIFT_STEP=8). Expected values are hand-computed constants.
module tb_alu_mt_pipe;

  localparam logic [2:0] OP_REG    = 3'd0;
  localparam logic [2:0] OP_IMM    = 3'd1;
  localparam logic [2:0] OP_LUI    = 3'd2;
  localparam logic [2:0] OP_AUIPC  = 3'd3;
  localparam logic [2:0] OP_JAL    = 3'd4;
  localparam logic [2:0] OP_JALR   = 3'd5;
  localparam logic [2:0] OP_BRANCH = 3'd6;
  localparam logic [2:0] OP_RSVD   = 3'd7;

  logic        clk, rst, in_valid, in_ready, alt, rd_en;
  logic [2:0]  op, funct3;
  logic [31:0] rs1_data, rs2_data, imm;
  logic [29:0] pc;
  logic [4:0]  rd_addr;
  logic [1:0]  thread_id;
  logic        out_valid, out_ready, out_rd_en, out_redirect, out_misalign, busy;
  logic [4:0]  out_rd_addr;
  logic [31:0] out_rd_data;
  logic [1:0]  out_thread_id;
  logic [29:0] out_new_pc;

  int tests = 0;
  int fails = 0;

  alu_mt_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .funct3(funct3), .alt(alt), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .imm(imm), .pc(pc), .rd_en(rd_en), .rd_addr(rd_addr), .thread_id(thread_id),
    .out_valid(out_valid), .out_ready(out_ready), .out_rd_en(out_rd_en),
    .out_rd_addr(out_rd_addr), .out_rd_data(out_rd_data), .out_thread_id(out_thread_id),
    .out_redirect(out_redirect), .out_new_pc(out_new_pc), .out_misalign(out_misalign),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected $finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [2:0] o, input logic [2:0] f3, input logic a,
                       input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] im,
                       input logic [29:0] p, input logic re, input logic [4:0] rd,
                       input logic [1:0] tid);
    op = o; funct3 = f3; alt = a; rs1_data = r1; rs2_data = r2; imm = im;
    pc = p; rd_en = re; rd_addr = rd; thread_id = tid; in_valid = 1'b1;
    $display("[TB] issue op=%0d f3=%0d alt=%0d rs1=0x%08h rs2=0x%08h imm=0x%08h pc=0x%08h rd=%0d tid=%0d",
             o, f3, a, r1, r2, im, p, rd, tid);
  endtask

  // Present the driven request for one edge; it must be accepted.
  task automatic accept_one(input string tag);
    chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic chk_pkt(input string tag, input logic re, input logic [4:0] rd,
                         input logic [31:0] data, input bit use_data, input logic [1:0] tid,
                         input logic redir, input logic [29:0] npc, input logic mis);
    chk({tag, ".out_valid"}, 32'(out_valid), 32'd1);
    chk({tag, ".rd_en"}, 32'(out_rd_en), 32'(re));
    chk({tag, ".rd_addr"}, 32'(out_rd_addr), 32'(rd));
    if (use_data) chk({tag, ".rd_data"}, out_rd_data, data);
    chk({tag, ".thread_id"}, 32'(out_thread_id), 32'(tid));
    chk({tag, ".redirect"}, 32'(out_redirect), 32'(redir));
    chk({tag, ".new_pc"}, 32'(out_new_pc), 32'(npc));
    chk({tag, ".misalign"}, 32'(out_misalign), 32'(mis));
  endtask

  // Single-cycle op: issue, check packet next cycle, then let it drain.
  task automatic one_op(input string tag, input logic [2:0] o, input logic [2:0] f3, input logic a,
                        input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] im,
                        input logic [29:0] p, input logic re, input logic [4:0] rd,
                        input logic [31:0] data, input bit use_data, input logic redir,
                        input logic [29:0] npc, input logic mis);
    drive(o, f3, a, r1, r2, im, p, 1'b1, rd, 2'd1);
    accept_one(tag);
    chk_pkt(tag, re, rd, data, use_data, 2'd1, redir, npc, mis);
    tick();
  endtask

  // Shift op: count busy cycles (bounded), check in_ready stays low, check packet.
  task automatic run_shift(input string tag, input logic [2:0] o, input logic [2:0] f3, input logic a,
                           input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] im,
                           input logic [31:0] data, input int cyc);
    int n;
    drive(o, f3, a, r1, r2, im, 30'h50, 1'b1, 5'd9, 2'd3);
    accept_one(tag);
    n = 0;
    while (busy && n < 40) begin
      n++;
      chk({tag, ".in_ready_busy"}, 32'(in_ready), 32'd0);
      tick();
    end
    chk({tag, ".busy_cycles"}, 32'(n), 32'(cyc));
    chk_pkt(tag, 1'b1, 5'd9, data, 1'b1, 2'd3, 1'b0, 30'h51, 1'b0);
    tick();
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    op = '0; funct3 = '0; alt = 1'b0; rs1_data = '0; rs2_data = '0; imm = '0;
    pc = '0; rd_en = 1'b0; rd_addr = '0; thread_id = '0;
    tick();
    tick();
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.in_ready", 32'(in_ready), 32'd0);
    chk("rst.rd_data", out_rd_data, 32'd0);
    chk("rst.new_pc", 32'(out_new_pc), 32'd0);
    chk("rst.rd_en", 32'(out_rd_en), 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst.in_ready", 32'(in_ready), 32'd1);

    // ADD overflow into the sign bit, with tag check
    drive(OP_REG, 3'b000, 1'b0, 32'h7FFF_FFFF, 32'h1, 32'h0, 30'h20, 1'b1, 5'd5, 2'd2);
    accept_one("add");
    chk_pkt("add", 1'b1, 5'd5, 32'h8000_0000, 1'b1, 2'd2, 1'b0, 30'h21, 1'b0);
    tick();
    chk("add.drained", 32'(out_valid), 32'd0);

    one_op("slt",   OP_REG, 3'b010, 1'b0, 32'hFFFF_FFFF, 32'h1, 32'h0, 30'h1, 1'b1, 5'd4, 32'h1, 1'b1, 1'b0, 30'h2, 1'b0);
    one_op("slti_ovf", OP_IMM, 3'b010, 1'b0, 32'h8000_0000, 32'h0, 32'h1, 30'h1, 1'b1, 5'd4, 32'h1, 1'b1, 1'b0, 30'h2, 1'b0);
    one_op("sltu",  OP_REG, 3'b011, 1'b0, 32'hFFFF_FFFF, 32'h1, 32'h0, 30'h1, 1'b1, 5'd4, 32'h0, 1'b1, 1'b0, 30'h2, 1'b0);
    one_op("sub",   OP_REG, 3'b000, 1'b1, 32'h0, 32'h1, 32'h0, 30'h1, 1'b1, 5'd4, 32'hFFFF_FFFF, 1'b1, 1'b0, 30'h2, 1'b0);
    one_op("addi_alt", OP_IMM, 3'b000, 1'b1, 32'h5, 32'h9, 32'h3, 30'h1, 1'b1, 5'd4, 32'h8, 1'b1, 1'b0, 30'h2, 1'b0);
    one_op("xor",   OP_REG, 3'b100, 1'b0, 32'hF0F0, 32'hFF00, 32'h0, 30'h1, 1'b1, 5'd4, 32'h0FF0, 1'b1, 1'b0, 30'h2, 1'b0);
    one_op("rd0",   OP_REG, 3'b000, 1'b0, 32'h1, 32'h2, 32'h0, 30'h1, 1'b0, 5'd0, 32'h3, 1'b1, 1'b0, 30'h2, 1'b0);
    one_op("lui",   OP_LUI, 3'b000, 1'b0, 32'h0, 32'h0, 32'h1234_5000, 30'h0, 1'b1, 5'd2, 32'h1234_5000, 1'b1, 1'b0, 30'h1, 1'b0);
    one_op("auipc", OP_AUIPC, 3'b000, 1'b0, 32'h0, 32'h0, 32'h1000, 30'h10, 1'b1, 5'd2, 32'h1040, 1'b1, 1'b0, 30'h11, 1'b0);
    one_op("pcwrap", OP_REG, 3'b000, 1'b0, 32'h1, 32'h1, 32'h0, 30'h3FFF_FFFF, 1'b1, 5'd2, 32'h2, 1'b1, 1'b0, 30'h0, 1'b0);
    one_op("rsvd",  OP_RSVD, 3'b000, 1'b0, 32'h1, 32'h1, 32'h8, 30'h100, 1'b0, 5'd2, 32'h0, 1'b0, 1'b0, 30'h101, 1'b0);

    // Control flow
    one_op("jal",   OP_JAL, 3'b000, 1'b0, 32'h0, 32'h0, 32'h20, 30'h10, 1'b1, 5'd1, 32'h44, 1'b1, 1'b1, 30'h18, 1'b0);
    one_op("jalr",  OP_JALR, 3'b000, 1'b0, 32'h1000, 32'h0, 32'h0, 30'h10, 1'b1, 5'd1, 32'h44, 1'b1, 1'b1, 30'h400, 1'b0);
    one_op("jalr_mis", OP_JALR, 3'b000, 1'b0, 32'h1002, 32'h0, 32'h0, 30'h10, 1'b0, 5'd1, 32'h0, 1'b0, 1'b1, 30'h400, 1'b1);
    one_op("bltu",  OP_BRANCH, 3'b110, 1'b0, 32'h1, 32'h2, 32'hFFFF_FFF8, 30'h100, 1'b0, 5'd3, 32'h0, 1'b0, 1'b1, 30'h0FE, 1'b0);
    one_op("bgeu",  OP_BRANCH, 3'b111, 1'b0, 32'h1, 32'h2, 32'hFFFF_FFF8, 30'h100, 1'b0, 5'd3, 32'h0, 1'b0, 1'b0, 30'h101, 1'b0);
    one_op("blt",   OP_BRANCH, 3'b100, 1'b0, 32'hFFFF_FFFF, 32'h1, 32'hFFFF_FFF8, 30'h100, 1'b0, 5'd3, 32'h0, 1'b0, 1'b1, 30'h0FE, 1'b0);
    one_op("br010", OP_BRANCH, 3'b010, 1'b0, 32'h7, 32'h7, 32'hFFFF_FFF8, 30'h100, 1'b0, 5'd3, 32'h0, 1'b0, 1'b0, 30'h101, 1'b0);
    one_op("beq_mis", OP_BRANCH, 3'b000, 1'b0, 32'h7, 32'h7, 32'h2, 30'h100, 1'b0, 5'd3, 32'h0, 1'b0, 1'b1, 30'h100, 1'b1);

    // Iterative shifts (SHIFT_STEP=8)
    run_shift("sra31", OP_REG, 3'b101, 1'b1, 32'h8000_0000, 32'd31, 32'h0, 32'hFFFF_FFFF, 4);
    run_shift("sra0",  OP_REG, 3'b101, 1'b1, 32'h8000_0000, 32'd0, 32'h0, 32'h8000_0000, 1);
    run_shift("srl31", OP_REG, 3'b101, 1'b0, 32'h8000_0000, 32'd31, 32'h0, 32'h1, 4);
    run_shift("sll16", OP_REG, 3'b001, 1'b0, 32'h1, 32'd16, 32'h0, 32'h1_0000, 2);
    run_shift("slli9", OP_IMM, 3'b001, 1'b1, 32'h1, 32'h0, 32'd9, 32'h200, 2);
    run_shift("srai4", OP_IMM, 3'b101, 1'b1, 32'hF000_0000, 32'h0, 32'h404, 32'hFF00_0000, 1);
    run_shift("srl_hi", OP_REG, 3'b101, 1'b0, 32'hFF00, 32'h28, 32'h0, 32'hFF, 1);

    // Backpressure: packet A held 3 cycles while B waits, then both in order
    out_ready = 1'b0;
    drive(OP_REG, 3'b000, 1'b0, 32'h1, 32'h1, 32'h0, 30'h40, 1'b1, 5'd6, 2'd1);
    accept_one("bp_a");
    drive(OP_REG, 3'b000, 1'b0, 32'h2, 32'h2, 32'h0, 30'h41, 1'b1, 5'd7, 2'd3);
    for (int i = 0; i < 3; i++) begin
      chk("bp_hold.in_ready", 32'(in_ready), 32'd0);
      chk("bp_hold.out_valid", 32'(out_valid), 32'd1);
      chk("bp_hold.rd_data", out_rd_data, 32'h2);
      chk("bp_hold.rd_addr", 32'(out_rd_addr), 32'd6);
      tick();
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release.in_ready", 32'(in_ready), 32'd1);
    chk_pkt("bp_a", 1'b1, 5'd6, 32'h2, 1'b1, 2'd1, 1'b0, 30'h41, 1'b0);
    tick();
    in_valid = 1'b0;
    chk_pkt("bp_b", 1'b1, 5'd7, 32'h4, 1'b1, 2'd3, 1'b0, 30'h42, 1'b0);
    tick();
    chk("bp.drained", 32'(out_valid), 32'd0);

    // Reset in the middle of a shift: operation abandoned, nothing emitted
    drive(OP_REG, 3'b101, 1'b1, 32'h8000_0000, 32'd31, 32'h0, 30'h60, 1'b1, 5'd8, 2'd0);
    accept_one("rst_mid");
    chk("rst_mid.busy0", 32'(busy), 32'd1);
    tick();
    chk("rst_mid.busy1", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    chk("rst_mid.out_valid", 32'(out_valid), 32'd0);
    chk("rst_mid.busy", 32'(busy), 32'd0);
    chk("rst_mid.in_ready", 32'(in_ready), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("rst_mid.no_pkt", 32'(out_valid), 32'd0);
      chk("rst_mid.idle", 32'(busy), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
